// File: rtl/fifo_feeder_pkg.sv
// Shared types and default widths for the fifo_feeder stream source.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_feeder_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;
   localparam int GAP_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } feeder_state_e;

endpackage : fifo_feeder_pkg

// File: rtl/fifo_feeder.sv
// Purpose: valid/ready traffic source emitting seed, seed+step, ... for cfg_len words,
//          with an optional idle gap after every transfer except the last.
// Latency: accept at edge N -> first valid in cycle N+1; done pulses the cycle after the last transfer.
// Backpressure: data_out_vld/data_out hold steady while data_out_rdy is low; vld never depends on rdy.
//
// Ports:
//   clk, rstn                      clock and asynchronous active-low reset
//   start                          launch a job (ignored while busy)
//   cfg_len/cfg_seed/cfg_step/cfg_gap   job configuration, captured on accept
//   data_out, data_out_vld, data_out_rdy   producer side of the stream
//   busy, done, sent_cnt           job status
module fifo_feeder
   import fifo_feeder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int GAP_W  = GAP_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic [DATA_W-1:0] cfg_seed,
   input  logic [DATA_W-1:0] cfg_step,
   input  logic [GAP_W-1:0]  cfg_gap,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_vld,
   input  logic              data_out_rdy,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sent_cnt
);

   feeder_state_e     state;
   logic [CNT_W-1:0]  len_q;
   logic [DATA_W-1:0] step_q;
   logic [GAP_W-1:0]  gap_q;
   logic [GAP_W-1:0]  gap_cnt;

   logic xfer;
   logic last_word;

   assign xfer      = data_out_vld && data_out_rdy;
   // The word being transferred now is the last one when it brings the count up to len.
   assign last_word = (sent_cnt + CNT_W'(1)) == len_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         len_q        <= '0;
         step_q       <= '0;
         gap_q        <= '0;
         gap_cnt      <= '0;
         data_out     <= '0;
         data_out_vld <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sent_cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  len_q    <= cfg_len;
                  step_q   <= cfg_step;
                  gap_q    <= cfg_gap;
                  sent_cnt <= '0;
                  data_out <= cfg_seed;
                  if (cfg_len == '0) begin
                     // Empty job: report completion without ever raising valid.
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state        <= SEND;
                     data_out_vld <= 1'b1;
                     busy         <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end

            SEND: begin
               if (xfer) begin
                  sent_cnt <= sent_cnt + CNT_W'(1);
                  data_out <= data_out + step_q;
                  if (last_word) begin
                     state        <= DONE;
                     data_out_vld <= 1'b0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                  end else if (gap_q != '0) begin
                     state        <= GAP;
                     gap_cnt      <= gap_q;
                     data_out_vld <= 1'b0;
                  end
               end
            end

            GAP: begin
               // Leaving at a count of 1 yields exactly gap_q low-valid cycles.
               if (gap_cnt == GAP_W'(1)) begin
                  state        <= SEND;
                  data_out_vld <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end

            default: begin
               state        <= IDLE;
               data_out_vld <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule : fifo_feeder
